shift_register_165: RTL and testbench

SHIFT_REGISTER_165 -- requirements
Module: shift_register_165

---
 rtl/shift_register_pkg.sv | 23 ++
 rtl/shift_register_165_if.sv | 23 ++
 rtl/shift_register_165.sv | 124 ++++++++++++
 tb/tb_shift_register_165.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_register_pkg.sv
// rtl/shift_register_pkg.sv - state encoding and default sizing shared by the 165 and 595 drivers
package shift_register_pkg;

  localparam int DEFAULT_NUM_ICS     = 2;
  localparam int DEFAULT_LOAD_CYCLES = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_SHIFT  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    SETTLE = ST_SETTLE,
    SAMPLE = ST_SAMPLE,
    SHIFT  = ST_SHIFT,
    DONE   = ST_DONE
  } sr_state_e;

endpackage

// File: rtl/shift_register_165_if.sv
// rtl/shift_register_165_if.sv - capture request, 165 chain pins and captured-word bundle
interface shift_register_165_if #(
  parameter int N = 16
);
  logic         trigger;
  logic         data;
  logic         sclk;
  logic         load_n;
  logic [N-1:0] word;
  logic         valid;
  logic         busy;
  logic         changed;

  // master: the capture engine; slave: the requester plus the 165 chain
  modport master (
    input  trigger, data,
    output sclk, load_n, word, valid, busy, changed
  );
  modport slave (
    input  sclk, load_n, word, valid, busy, changed,
    output trigger, data
  );
endinterface

// File: rtl/shift_register_165.sv
// rtl/shift_register_165.sv - 74HC165 chain reader; SR165_CHANGE_DETECT_EN enables changed_o
module shift_register_165
  import shift_register_pkg::*;
#(
  parameter int NUM_ICS     = DEFAULT_NUM_ICS,
  parameter int LOAD_CYCLES = DEFAULT_LOAD_CYCLES
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   trigger_i,
  input  logic                   data_i,
  output logic                   sclk_o,
  output logic                   load_n_o,
  output logic [NUM_ICS*8-1:0]   data_o,
  output logic                   valid_o,
  output logic                   busy_o,
  output logic                   changed_o
);

  localparam int         N     = NUM_ICS * 8;
  localparam int         CW    = $clog2(N);
  localparam logic [3:0] LC_M1 = 4'(LOAD_CYCLES - 1);

  sr_state_e      state_q, state_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]     load_cnt_q, load_cnt_d;
  logic [N-1:0]   cap_q, cap_d;
  logic [N-1:0]   data_q, data_d;
`ifdef SR165_CHANGE_DETECT_EN
  logic           changed_q, changed_d;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    load_cnt_d = load_cnt_q;
    cap_d      = cap_q;
    data_d     = data_q;
`ifdef SR165_CHANGE_DETECT_EN
    changed_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (trigger_i) begin
          state_d    = LOAD;
          load_cnt_d = LC_M1;
        end
      end
      LOAD: begin
        if (load_cnt_q == 4'd0) begin
          state_d = SETTLE;
        end else begin
          load_cnt_d = load_cnt_q - 4'd1;
        end
      end
      SETTLE: begin
        state_d   = SAMPLE;
        bit_cnt_d = CW'(N - 1);
      end
      SAMPLE: begin
        cap_d[bit_cnt_q] = data_i;
        state_d          = SHIFT;
      end
      SHIFT: begin
        // publish on the way into DONE so data_o and valid_o line up
        if (bit_cnt_q == '0) begin
          state_d = DONE;
          data_d  = cap_q;
`ifdef SR165_CHANGE_DETECT_EN
          changed_d = (cap_q != data_q);
`endif
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
          state_d   = SAMPLE;
        end
      end
      DONE: begin
        if (trigger_i) begin
          state_d    = LOAD;
          load_cnt_d = LC_M1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      load_cnt_q <= '0;
      cap_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      load_cnt_q <= load_cnt_d;
      cap_q      <= cap_d;
      data_q     <= data_d;
    end
  end

`ifdef SR165_CHANGE_DETECT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end
  assign changed_o = changed_q;
`else
  assign changed_o = 1'b0;
`endif

  assign sclk_o   = (state_q == SHIFT);
  assign load_n_o = (state_q != LOAD);
  assign valid_o  = (state_q == DONE);
  assign busy_o   = (state_q != IDLE);
  assign data_o   = data_q;

endmodule

// File: tb/tb_shift_register_165.sv
// tb/tb_shift_register_165.sv - randomized and directed bench for the 165 chain reader
module tb_shift_register_165;

  localparam int NI = 2;
  localparam int N  = NI * 8;
  localparam int L  = 2;
  localparam int T  = L + 1 + 2 * N;
  localparam int N2 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  shift_register_165_if #(.N(N))  bus ();
  shift_register_165_if #(.N(N2)) bus2 ();

  shift_register_165 #(.NUM_ICS(NI), .LOAD_CYCLES(L)) dut (
    .clk_i(clk), .rst_i(rst), .trigger_i(bus.trigger), .data_i(bus.data),
    .sclk_o(bus.sclk), .load_n_o(bus.load_n), .data_o(bus.word),
    .valid_o(bus.valid), .busy_o(bus.busy), .changed_o(bus.changed)
  );

  shift_register_165 #(.NUM_ICS(1), .LOAD_CYCLES(1)) dut2 (
    .clk_i(clk), .rst_i(rst2), .trigger_i(bus2.trigger), .data_i(bus2.data),
    .sclk_o(bus2.sclk), .load_n_o(bus2.load_n), .data_o(bus2.word),
    .valid_o(bus2.valid), .busy_o(bus2.busy), .changed_o(bus2.changed)
  );

  // 74HC165 chains: level load while PL low, shift toward Q7 on CP rise
  logic [N-1:0]  par1 = '0, sr1 = '0;
  logic [N2-1:0] par2 = '0, sr2 = '0;
  always @(posedge bus.sclk or negedge bus.load_n)
    if (!bus.load_n) sr1 <= par1; else sr1 <= {sr1[N-2:0], 1'b0};
  always @(posedge bus2.sclk or negedge bus2.load_n)
    if (!bus2.load_n) sr2 <= par2; else sr2 <= {sr2[N2-2:0], 1'b0};
  assign bus.data  = sr1[N-1];
  assign bus2.data = sr2[N2-1];

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: t = cycles since the accepting edge, -1 when idle
  int           t = -1;
  logic [N-1:0] snap = '0, exp_word = '0;
  logic         exp_chg = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      t = -1; exp_word = '0; exp_chg = 1'b0;
    end else begin
      exp_chg = 1'b0;
      if (t < 0 || t == T) begin
        if (bus.trigger) begin t = 0; snap = par1; end
        else t = -1;
      end else begin
        t++;
        if (t == T) begin
`ifdef SR165_CHANGE_DETECT_EN
          exp_chg = (snap != exp_word);
`endif
          exp_word = snap;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("load_n_o", bus.load_n, (t >= 0 && t < L) ? 0 : 1);
      chk("sclk_o",   bus.sclk,   (t > L && t < T && ((t - L - 1) % 2 == 1)) ? 1 : 0);
      chk("valid_o",  bus.valid,  (t == T) ? 1 : 0);
      chk("busy_o",   bus.busy,   (t >= 0) ? 1 : 0);
      chk("data_o",   bus.word,   exp_word);
      chk("changed_o", bus.changed, exp_chg);
    end
  end

  int   sclk_rises = 0;
  int   load_lo = 0;
  logic sclk_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.sclk === 1'b1 && sclk_prev === 1'b0) sclk_rises++;
    if (bus.load_n === 1'b0) load_lo++;
    sclk_prev = bus.sclk;
  end

  task automatic capture1(input logic [N-1:0] w, output int lat);
    @(negedge clk);
    par1 = w; sclk_rises = 0; load_lo = 0; bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
    lat = 0;
    while (bus.valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int lat, last, nval, g;
  logic [2:0] chg_seen;

  initial begin
    bus.trigger = 1'b0;
    bus2.trigger = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset data_o", bus.word, 0);
    chk("reset busy_o", bus.busy, 0);
    chk("reset load_n_o", bus.load_n, 1);
    chk("reset sclk_o", bus.sclk, 0);
    chk("reset valid_o", bus.valid, 0);
    chk_en = 1'b1;
    rst = 1'b0;
    rst2 = 1'b0;

    // basic capture
    capture1(16'hA5C3, lat);
    chk("basic latency", lat, 35);
    chk("basic word", bus.word, 16'hA5C3);
    chk("basic sclk rises", sclk_rises, 16);
    chk("basic load_n low cycles", load_lo, 2);

    // trigger held high: back-to-back via DONE->LOAD
    @(negedge clk);
    par1 = 16'h3C96; bus.trigger = 1'b1;
    last = -1; nval = 0;
    for (int c = 0; c < 3 * 36 + 10; c++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        if (last >= 0) chk("b2b interval", c - last, 36);
        last = c; nval++;
      end
    end
    chk("b2b valid count", nval, 3);
    bus.trigger = 1'b0;
    g = 0;
    while (bus.busy !== 1'b0 && g < 100) begin @(negedge clk); g++; end
    chk("b2b drains", bus.busy, 0);

    // trigger pulse while shifting bit 7 is ignored
    @(negedge clk);
    par1 = 16'h5AA5; bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
    g = 0;
    while (t != L + 2 + 2 * (N - 1 - 7) && g < 100) begin @(negedge clk); g++; end
    chk("bit7 shift phase", bus.sclk, 1);
    bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
    g = 0;
    while (bus.valid !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    chk("busy-trig word", bus.word, 16'h5AA5);
    @(negedge clk);
    chk("busy drops after done", bus.busy, 0);
    nval = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) nval++;
    end
    chk("busy-trig extra valids", nval, 0);

    // reset during SAMPLE aborts
    @(negedge clk);
    par1 = 16'hFFFF; bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
    g = 0;
    while (t != L + 1 + 6 && g < 100) begin @(negedge clk); g++; end
    chk("abort in sample", bus.sclk, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort data_o", bus.word, 0);
    chk("abort load_n_o", bus.load_n, 1);
    chk("abort busy_o", bus.busy, 0);
    nval = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) nval++;
    end
    chk("abort no valid", nval, 0);
    capture1(16'h0F0F, lat);
    chk("post-abort latency", lat, 35);
    chk("post-abort word", bus.word, 16'h0F0F);

    // change detection sequence
    capture1(16'h1234, lat); chg_seen[0] = bus.changed;
    capture1(16'h1234, lat); chg_seen[1] = bus.changed;
    capture1(16'h8001, lat); chg_seen[2] = bus.changed;
`ifdef SR165_CHANGE_DETECT_EN
    chk("changed sequence", chg_seen, 3'b101);
`else
    chk("changed sequence", chg_seen, 3'b000);
`endif

    // one IC, one load cycle
    @(negedge clk);
    par2 = 8'h5A; bus2.trigger = 1'b1;
    @(negedge clk);
    bus2.trigger = 1'b0;
    lat = 0;
    while (bus2.valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    chk("small latency", lat, 18);
    chk("small word", bus2.word, 8'h5A);
    @(negedge clk);
    chk("small idle", bus2.busy, 0);

    // random triggers, words and occasional resets against the reference
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      par1 = N'($urandom);
      bus.trigger = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 150) == 0);
    end
    @(negedge clk);
    bus.trigger = 1'b0; rst = 1'b0;
    repeat (T + 5) @(negedge clk);
    chk("final idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
